// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path: access size encoding (common to
// the load unit and the store formatter) and the load FSM state encoding.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_BYTE    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_REQ  = 2'b01,
        LD_WAIT = 2'b10,
        LD_RESP = 2'b11
    } ld_state_e;

    // A half must sit on an even byte, a word on a 4-byte boundary.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Bundle of the core-side load handshake, the data-memory read port and the
// write-back port of the load unit.
interface load_data_unit_if
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    mem_size_e         ld_size;
    logic              ld_unsigned;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    logic              wb_valid;
    logic [XLEN-1:0]   wb_data;
    logic              wb_err;
    logic              busy;

    // Core and memory side, driving loads and read responses.
    modport master (
        output ld_valid, ld_addr, ld_size, ld_unsigned,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_err, busy
    );

    // The load unit itself.
    modport slave (
        input  ld_valid, ld_addr, ld_size, ld_unsigned,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_err, busy
    );

endinterface

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a 32-bit read word for
// byte, half and word loads.
module load_extract
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        // Only addr[1] picks the half; addr[0] is a misalignment matter.
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = 32'h0;
        case (size)
            SZ_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SZ_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            SZ_WORD: data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// Single-outstanding load unit: issues a word-aligned read, extracts and extends
// the addressed lane, and returns it with a one-cycle write-back pulse.
// Optional misalignment trap: define LOAD_MISALIGN_TRAP_EN.
module load_data_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
)(
    input  logic           clk,
    input  logic           rst,
    load_data_unit_if.slave bus
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    mem_size_e         size_q;
    logic              unsigned_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              wb_err_q;

    logic              ld_ready_c;
    logic              mem_req_c;
    logic              wb_valid_c;
    logic              trap;
    logic              accept_err;
    logic [31:0]       ext_data;

`ifdef LOAD_MISALIGN_TRAP_EN
    assign trap = is_misaligned(bus.ld_size, bus.ld_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Faulting loads skip the memory entirely and go straight to RESP.
    assign accept_err = (bus.ld_size == SZ_ILLEGAL) || trap;

    load_extract u_extract (
        .rdata       (bus.mem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (ext_data)
    );

    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_ready_c = 1'b0;
        mem_req_c  = 1'b0;
        wb_valid_c = 1'b0;
        case (state_q)
            LD_IDLE: begin
                ld_ready_c = 1'b1;
                if (bus.ld_valid) begin
                    state_d = accept_err ? LD_RESP : LD_REQ;
                end
            end
            LD_REQ: begin
                mem_req_c = 1'b1;
                if (bus.mem_gnt) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = LD_RESP;
                end
            end
            LD_RESP: begin
                wb_valid_c = 1'b1;
                state_d    = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // Result registers only change on the edge that enters RESP, so wb_data and
    // wb_err stay put in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            size_q     <= SZ_WORD;
            unsigned_q <= 1'b0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (bus.ld_valid) begin
                        addr_q     <= bus.ld_addr;
                        size_q     <= bus.ld_size;
                        unsigned_q <= bus.ld_unsigned;
                        if (accept_err) begin
                            wb_data_q <= '0;
                            wb_err_q  <= 1'b1;
                        end
                    end
                end
                LD_WAIT: begin
                    if (bus.mem_rvalid) begin
                        wb_data_q <= bus.mem_err ? '0 : ext_data;
                        wb_err_q  <= bus.mem_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready = ld_ready_c;
    assign bus.mem_req  = mem_req_c;
    assign bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.wb_valid = wb_valid_c;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_err   = wb_err_q;
    assign bus.busy     = (state_q != LD_IDLE);

endmodule

// File: tb/tb_load_data_unit.sv
// Directed, table-driven bench for load_data_unit: zero-wait and stalled memory,
// all extraction lanes, error paths, and reset in the middle of a load.
module tb_load_data_unit;
    import riscv_mem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        mem_size_e   size;
        logic        uns;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        err;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_req;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    load_data_unit_if #(.ADDR_W(32), .XLEN(32)) bus ();

    load_data_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] a, input mem_size_e s, input logic u,
                                input logic [31:0] rd, input int g, input logic e,
                                input logic [31:0] xd, input logic xe, input logic xr);
        vec_t v;
        v.addr = a; v.size = s; v.uns = u; v.rdata = rd; v.gnt_dly = g; v.err = e;
        v.exp_data = xd; v.exp_err = xe; v.exp_req = xr;
        v.exp_lat = xr ? 3 + g : 1;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = 32'h0;
        bus.ld_size     = SZ_WORD;
        bus.ld_unsigned = 1'b0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'h0;
        bus.mem_err     = 1'b0;
    endtask

    // Presents one load and plays the memory: grant after gnt_dly stalled REQ
    // cycles, read data on the cycle after the grant, junk rvalid while in REQ.
    task automatic run_load(input vec_t v, input int idx);
        int          req_cnt;
        int          lat;
        bit          granted;
        bit          addr_ok;
        bit          busy_ok;
        logic [31:0] got_data;
        logic [31:0] got_err;
        logic [31:0] exp_addr;
        req_cnt = 0; lat = -1; granted = 0; addr_ok = 1; busy_ok = 1;
        got_data = 32'hx; got_err = 32'hx;
        exp_addr = {v.addr[31:2], 2'b00};

        @(negedge clk);
        check($sformatf("v%0d ld_ready", idx), {31'b0, bus.ld_ready}, 32'd1);
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = v.addr;
        bus.ld_size     = v.size;
        bus.ld_unsigned = v.uns;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'hFFFF_FFFF;

        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
            bus.mem_rdata  = 32'hA5A5_A5A5;
            if (!bus.busy) busy_ok = 0;
            if (bus.wb_valid) begin
                lat      = c;
                got_data = bus.wb_data;
                got_err  = {31'b0, bus.wb_err};
            end else if (granted) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.rdata;
                bus.mem_err    = v.err;
                granted        = 0;
            end else if (bus.mem_req) begin
                req_cnt++;
                if (bus.mem_addr !== exp_addr) addr_ok = 0;
                if (req_cnt > v.gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    granted     = 1;
                end else begin
                    bus.mem_rvalid = 1'b1;
                end
            end
        end

        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d wb_data", idx), got_data, v.exp_data);
        check($sformatf("v%0d wb_err", idx), got_err, {31'b0, v.exp_err});
        check($sformatf("v%0d req_cycles", idx), 32'(req_cnt),
              v.exp_req ? 32'(v.gnt_dly + 1) : 32'd0);
        check($sformatf("v%0d mem_addr_stable", idx), {31'b0, addr_ok}, 32'd1);
        check($sformatf("v%0d busy", idx), {31'b0, busy_ok}, 32'd1);

        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check($sformatf("v%0d wb_pulse_one_cycle", idx), {31'b0, bus.wb_valid}, 32'd0);
        check($sformatf("v%0d ready_after", idx), {31'b0, bus.ld_ready}, 32'd1);
        check($sformatf("v%0d wb_data_held", idx), bus.wb_data, v.exp_data);
    endtask

    initial begin
        int wb_seen;

        add(32'h1003, SZ_BYTE, 1'b0, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1);
        add(32'h1003, SZ_BYTE, 1'b1, 32'h80FF_1234, 0, 1'b0, 32'h0000_0080, 1'b0, 1'b1);
        add(32'h1001, SZ_BYTE, 1'b0, 32'h80FF_1234, 0, 1'b0, 32'h0000_0012, 1'b0, 1'b1);
        add(32'h1002, SZ_BYTE, 1'b0, 32'h80FF_1234, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        add(32'h1002, SZ_BYTE, 1'b1, 32'h80FF_1234, 0, 1'b0, 32'h0000_00FF, 1'b0, 1'b1);
        add(32'h1000, SZ_BYTE, 1'b0, 32'h80FF_1234, 0, 1'b0, 32'h0000_0034, 1'b0, 1'b1);
        add(32'h1002, SZ_HALF, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1);
        add(32'h1000, SZ_HALF, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'h0000_7FFF, 1'b0, 1'b1);
        add(32'h1002, SZ_HALF, 1'b1, 32'h8001_7FFF, 0, 1'b0, 32'h0000_8001, 1'b0, 1'b1);
        add(32'h2000, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        add(32'h4000, SZ_WORD, 1'b1, 32'h8765_4321, 0, 1'b0, 32'h8765_4321, 1'b0, 1'b1);
        add(32'h3000, SZ_WORD, 1'b0, 32'h1234_5678, 2, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        add(32'h1000, SZ_ILLEGAL, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef LOAD_MISALIGN_TRAP_EN
        add(32'h1001, SZ_HALF, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        add(32'h2002, SZ_WORD, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`else
        add(32'h1001, SZ_HALF, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'h0000_7FFF, 1'b0, 1'b1);
        add(32'h2002, SZ_WORD, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);
`endif

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset ld_ready", {31'b0, bus.ld_ready}, 32'd1);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("reset wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        check("reset wb_err", {31'b0, bus.wb_err}, 32'd0);
        check("reset wb_data", bus.wb_data, 32'h0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_load(vecs[i], i);

        // Reset while waiting for read data; the late response must be dropped.
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h5004;
        bus.ld_size  = SZ_WORD;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        @(negedge clk);
        check("rst_mid mem_req", {31'b0, bus.mem_req}, 32'd1);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_mid busy_async", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        wb_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bus.wb_valid) wb_seen++;
        end
        check("rst_mid no_wb_valid", 32'(wb_seen), 32'd0);
        check("rst_mid ld_ready", {31'b0, bus.ld_ready}, 32'd1);
        check("rst_mid busy", {31'b0, bus.busy}, 32'd0);
        check("rst_mid wb_data", bus.wb_data, 32'h0);

        // An illegal-size load straight after the reset still faults cleanly.
        run_load(vecs[12], 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
